// File: rtl/comb_sel_gen.sv
// comb_sel_gen: walks the fit-combination enable mask of one road at a time,
// lowest index first, and emits one selector index per cycle towards the
// select pipeline register. Supports downstream stall and zero-bubble
// back-to-back roads.
module comb_sel_gen #(
  parameter int SEL_W = 3,
  parameter int NCOMB = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             roadValid_i,
  input  logic [NCOMB-1:0] roadMask_i,
  output logic             roadReady_o,
  input  logic             hold_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             selValid_o,
  output logic             selLast_o,
  output logic             emptyRoad_o,
  output logic [CNT_W-1:0] combCount_o
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [NCOMB-1:0] rem_q, rem_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             selValid_q, selValid_d;
  logic             selLast_q, selLast_d;
  logic             emptyRoad_q, emptyRoad_d;
  logic [CNT_W-1:0] combCount_q, combCount_d;

  logic [SEL_W-1:0] lowIdx;
  logic [NCOMB-1:0] remCleared;
  logic             remOneBit;
  logic             accept;
  logic             maskZero;

  // Lowest set bit of the remaining mask, plus the mask with that bit removed
  always_comb begin
    lowIdx = '0;
    for (int i = NCOMB - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        lowIdx = SEL_W'(i);
      end
    end
    remCleared = rem_q & (rem_q - NCOMB'(1));
    remOneBit  = (rem_q != '0) && (remCleared == '0);
  end

  // A new road can enter when idle, or on the edge that emits the final selector
  always_comb begin
    roadReady_o = (state_q == IDLE) || ((state_q == EMIT) && remOneBit && !hold_i);
    accept      = roadValid_i && roadReady_o;
    maskZero    = (roadMask_i == '0);
  end

  // Next-state and next-output computation for the emit walker
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    sel_d       = sel_q;
    selValid_d  = 1'b0;
    selLast_d   = 1'b0;
    emptyRoad_d = 1'b0;
    combCount_d = combCount_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (maskZero) begin
            emptyRoad_d = 1'b1;
          end else begin
            rem_d   = roadMask_i;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (!hold_i) begin
          sel_d      = lowIdx;
          selValid_d = 1'b1;
          selLast_d  = remOneBit;
          rem_d      = remCleared;
          if (combCount_q != '1) begin
            combCount_d = combCount_q + CNT_W'(1);
          end
          if (remOneBit) begin
            if (accept && !maskZero) begin
              rem_d = roadMask_i;
            end else begin
              state_d = IDLE;
              if (accept) begin
                emptyRoad_d = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset discards any road in flight
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      sel_q       <= '0;
      selValid_q  <= 1'b0;
      selLast_q   <= 1'b0;
      emptyRoad_q <= 1'b0;
      combCount_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      sel_q       <= sel_d;
      selValid_q  <= selValid_d;
      selLast_q   <= selLast_d;
      emptyRoad_q <= emptyRoad_d;
      combCount_q <= combCount_d;
    end
  end

  assign sel_o       = sel_q;
  assign selValid_o  = selValid_q;
  assign selLast_o   = selLast_q;
  assign emptyRoad_o = emptyRoad_q;
  assign combCount_o = combCount_q;

endmodule
